way_select_pipe: RTL and testbench



---
 rtl/way_select_pipe.sv | 118 +++++++++++
 tb/tb_way_select_pipe.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/way_select_pipe.sv
// way_select_pipe: picks one way's field from a flat per-way bus into a 2-entry in-order skid
// buffer with valid/ready on both sides. Define WAY_SELECT_PARITY_EN to add per-entry out_par.
module way_select_pipe #(
  parameter int unsigned DATA_W   = 3,
  parameter int unsigned NUM_WAYS = 8,
  parameter int unsigned SEL_W    = 3
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_WAYS*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]           in_sel,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [SEL_W-1:0]           out_sel,
`ifdef WAY_SELECT_PARITY_EN
  output logic                       out_par,
`endif
  output logic                       out_err
);

  localparam int unsigned SelLsb = DATA_W;
  localparam int unsigned ErrBit = DATA_W + SEL_W;
`ifdef WAY_SELECT_PARITY_EN
  localparam int unsigned ParBit = ErrBit + 1;
  localparam int unsigned EntW   = ErrBit + 2;
`else
  localparam int unsigned EntW   = ErrBit + 1;
`endif

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e          state_q, state_d;
  logic [EntW-1:0] head_q, head_d;
  logic [EntW-1:0] tail_q, tail_d;
  logic [EntW-1:0] new_ent;
  logic [DATA_W-1:0] sel_data;
  logic            sel_err;
  logic            accept;
  logic            pop;

  // Out-of-range selects match no way, so they fall through to zero data.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_WAYS; i++) begin
      if (in_sel == SEL_W'(i)) begin
        sel_data = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign sel_err = (32'(in_sel) >= NUM_WAYS);

`ifdef WAY_SELECT_PARITY_EN
  assign new_ent = {^sel_data, sel_err, in_sel, sel_data};
`else
  assign new_ent = {sel_err, in_sel, sel_data};
`endif

  // in_ready depends only on registered state, so out_ready never reaches it.
  assign in_ready  = reset_n && (state_q != StFull);
  assign out_valid = (state_q != StEmpty);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          head_d  = new_ent;
          state_d = StOne;
        end
      end
      StOne: begin
        if (accept && pop) begin
          head_d = new_ent;
        end else if (accept) begin
          tail_d  = new_ent;
          state_d = StFull;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StEmpty;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign out_data = head_q[DATA_W-1:0];
  assign out_sel  = head_q[SelLsb +: SEL_W];
  assign out_err  = head_q[ErrBit];
`ifdef WAY_SELECT_PARITY_EN
  assign out_par  = head_q[ParBit];
`endif

endmodule

// File: tb/tb_way_select_pipe.sv
// Bench for way_select_pipe: an 8-way default instance and a 6-way/6-bit instance, each checked
// every cycle against a queue model, plus literal expectations.
module tb_way_select_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
  logic [23:0] a_in_data;
  logic [2:0]  a_in_sel, a_out_sel, a_out_data;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
  logic [35:0] b_in_data;
  logic [2:0]  b_in_sel, b_out_sel;
  logic [5:0]  b_out_data;

`ifdef WAY_SELECT_PARITY_EN
  logic a_out_par, b_out_par;
`endif

  way_select_pipe dut_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .in_sel    (a_in_sel),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .out_sel   (a_out_sel),
`ifdef WAY_SELECT_PARITY_EN
    .out_par   (a_out_par),
`endif
    .out_err   (a_out_err)
  );

  way_select_pipe #(
    .DATA_W   (6),
    .NUM_WAYS (6),
    .SEL_W    (3)
  ) dut_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .in_sel    (b_in_sel),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .out_sel   (b_out_sel),
`ifdef WAY_SELECT_PARITY_EN
    .out_par   (b_out_par),
`endif
    .out_err   (b_out_err)
  );

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  typedef struct packed {
    logic [5:0] data;
    logic [2:0] sel;
    logic       err;
  } ent_t;

  ent_t qa[$];
  ent_t qb[$];
  bit   a_acc, a_pop, b_acc, b_pop;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t make_ent(input logic [63:0] flat, input int ways, input int dw,
                                    input logic [2:0] sel);
    ent_t e;
    logic [63:0] mask;
    mask   = (64'd1 << dw) - 64'd1;
    e.sel  = sel;
    e.err  = (int'(sel) >= ways);
    e.data = e.err ? 6'd0 : 6'((flat >> (int'(sel) * dw)) & mask);
    return e;
  endfunction

  // Model: a pop removes the oldest entry, an accept appends; capacity two, cleared by reset.
  always @(posedge clk) begin
    if (!reset_n) begin
      qa.delete();
      qb.delete();
    end else begin
      a_acc = a_in_valid && (qa.size() < 2);
      a_pop = (qa.size() > 0) && a_out_ready;
      b_acc = b_in_valid && (qb.size() < 2);
      b_pop = (qb.size() > 0) && b_out_ready;
      if (a_pop) void'(qa.pop_front());
      if (a_acc) qa.push_back(make_ent(64'(a_in_data), 8, 3, a_in_sel));
      if (b_pop) void'(qb.pop_front());
      if (b_acc) qb.push_back(make_ent(64'(b_in_data), 6, 6, b_in_sel));
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("a.in_ready", 64'(a_in_ready), 64'(reset_n && (qa.size() < 2)));
      check("a.out_valid", 64'(a_out_valid), 64'(qa.size() != 0));
      if (qa.size() != 0) begin
        check("a.out_data", 64'(a_out_data), 64'(qa[0].data));
        check("a.out_sel", 64'(a_out_sel), 64'(qa[0].sel));
        check("a.out_err", 64'(a_out_err), 64'(qa[0].err));
`ifdef WAY_SELECT_PARITY_EN
        check("a.out_par", 64'(a_out_par), 64'(^qa[0].data));
`endif
      end
      check("b.in_ready", 64'(b_in_ready), 64'(reset_n && (qb.size() < 2)));
      check("b.out_valid", 64'(b_out_valid), 64'(qb.size() != 0));
      if (qb.size() != 0) begin
        check("b.out_data", 64'(b_out_data), 64'(qb[0].data));
        check("b.out_sel", 64'(b_out_sel), 64'(qb[0].sel));
        check("b.out_err", 64'(b_out_err), 64'(qb[0].err));
`ifdef WAY_SELECT_PARITY_EN
        check("b.out_par", 64'(b_out_par), 64'(^qb[0].data));
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_a_head(input string name, input logic [2:0] data, input logic [2:0] sel,
                              input logic err);
    check({name, ".valid"}, 64'(a_out_valid), 64'd1);
    check({name, ".data"}, 64'(a_out_data), 64'(data));
    check({name, ".sel"}, 64'(a_out_sel), 64'(sel));
    check({name, ".err"}, 64'(a_out_err), 64'(err));
  endtask

  task automatic check_a_zero(input string name);
    check({name, ".valid"}, 64'(a_out_valid), 64'd0);
    check({name, ".data"}, 64'(a_out_data), 64'd0);
    check({name, ".sel"}, 64'(a_out_sel), 64'd0);
    check({name, ".err"}, 64'(a_out_err), 64'd0);
`ifdef WAY_SELECT_PARITY_EN
    check({name, ".par"}, 64'(a_out_par), 64'd0);
`endif
  endtask

  initial begin
    reset_n     = 1'b0;
    a_in_valid  = 1'b0;
    a_out_ready = 1'b0;
    a_in_sel    = '0;
    b_in_valid  = 1'b0;
    b_out_ready = 1'b0;
    b_in_sel    = '0;
    for (int i = 0; i < 8; i++) a_in_data[i*3 +: 3] = 3'(i);
    for (int i = 0; i < 6; i++) b_in_data[i*6 +: 6] = 6'(6'h21 + i);

    step();
    cmp_en = 1'b1;
    step();
    check_a_zero("reset");
    check("reset.in_ready_low", 64'(a_in_ready), 64'd0);
    reset_n = 1'b1;
    #1;
    check("reset.in_ready_high", 64'(a_in_ready), 64'd1);

    // Single accept, then streaming at one per cycle.
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_sel    = 3'd5;
    step();
    check_a_head("sel5", 3'd5, 3'd5, 1'b0);
    a_in_sel = 3'd0;
    step();
    check_a_head("sel0", 3'd0, 3'd0, 1'b0);
    a_in_sel = 3'd7;
    step();
    check_a_head("sel7", 3'd7, 3'd7, 1'b0);
`ifdef WAY_SELECT_PARITY_EN
    check("par111", 64'(a_out_par), 64'd1);
`endif
    a_in_valid = 1'b0;
    step();
    check("drain.valid", 64'(a_out_valid), 64'd0);

    // Back-pressure fills the buffer; third request is held off.
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_sel    = 3'd2;
    step();
    a_in_sel = 3'd6;
    step();
    check("full.in_ready", 64'(a_in_ready), 64'd0);
    check_a_head("full.head", 3'd2, 3'd2, 1'b0);
    a_in_sel = 3'd3;
    step();
    check_a_head("hold.head", 3'd2, 3'd2, 1'b0);
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    step();
    check_a_head("pop1.head", 3'd6, 3'd6, 1'b0);
    check("pop1.in_ready", 64'(a_in_ready), 64'd1);
`ifdef WAY_SELECT_PARITY_EN
    check("par110", 64'(a_out_par), 64'd0);
`endif
    step();
    check("pop2.valid", 64'(a_out_valid), 64'd0);

    // Out-of-range selects on the 6-way instance.
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    b_in_sel    = 3'd7;
    step();
    check("b.sel7.data", 64'(b_out_data), 64'd0);
    check("b.sel7.err", 64'(b_out_err), 64'd1);
    check("b.sel7.sel", 64'(b_out_sel), 64'd7);
    b_in_sel = 3'd5;
    step();
    check("b.sel5.data", 64'(b_out_data), 64'h26);
    check("b.sel5.err", 64'(b_out_err), 64'd0);
    b_in_sel = 3'd6;
    step();
    check("b.sel6.err", 64'(b_out_err), 64'd1);
    check("b.sel6.data", 64'(b_out_data), 64'd0);
    b_in_valid = 1'b0;
    step();

    // Accept and pop together in ONE: new entry becomes head, nothing lost or repeated.
    a_in_valid = 1'b1;
    a_in_sel   = 3'd4;
    step();
    check_a_head("one.head4", 3'd4, 3'd4, 1'b0);
    a_in_sel = 3'd3;
    step();
    check_a_head("one.head3", 3'd3, 3'd3, 1'b0);
    a_in_valid = 1'b0;
    step();
    check("one.drain", 64'(a_out_valid), 64'd0);

    // Reset while FULL discards everything.
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_sel    = 3'd2;
    step();
    a_in_sel = 3'd6;
    step();
    check("rfull.in_ready", 64'(a_in_ready), 64'd0);
    reset_n     = 1'b0;
    a_out_ready = 1'b1;
    #1;
    check("rst.in_ready_forced", 64'(a_in_ready), 64'd0);
    step();
    check_a_zero("rst_full");
    reset_n  = 1'b1;
    a_in_sel = 3'd1;
    #1;
    check("rst_full.in_ready", 64'(a_in_ready), 64'd1);
    step();
    check_a_head("post_rst", 3'd1, 3'd1, 1'b0);
    a_in_valid = 1'b0;
    step();

    // Directed mixed traffic; the per-cycle compare process checks it against the model.
    for (int i = 0; i < 40; i++) begin
      a_in_valid  = (i % 3) != 2;
      a_out_ready = ((i % 4) != 1) && ((i % 5) != 3);
      a_in_sel    = 3'((i * 5) % 8);
      a_in_data   = 24'($urandom);
      b_in_valid  = (i % 4) != 3;
      b_out_ready = (i % 3) != 0;
      b_in_sel    = 3'((i * 3) % 8);
      b_in_data   = {4'($urandom), 32'($urandom)};
      step();
    end
    a_in_valid  = 1'b0;
    b_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    repeat (3) step();
    check("end.a_empty", 64'(a_out_valid), 64'd0);
    check("end.b_empty", 64'(b_out_valid), 64'd0);
    cmp_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
